// File: rtl/button_capture.sv
// Button capture: 2-flop sync, debounce FSM, one-hot validation, single-cycle strobes.
// Optional press counter enabled by BUTTON_CAPTURE_PRESS_COUNT_EN.
`timescale 1ns/1ps
module button_capture #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] btn_in,
    output logic [1:0] colour_val,
    output logic       colour_valid,
    output logic       multi_press,
    output logic       btn_held,
    output logic [7:0] press_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t        state, state_nxt;
    logic [3:0]    sync1, s, snapshot, snapshot_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    colour_nxt;
    logic          valid_nxt, multi_nxt, snap_onehot;

    assign snap_onehot = (snapshot != 4'd0) && ((snapshot & (snapshot - 4'd1)) == 4'd0);

    function automatic logic [1:0] encode(input logic [3:0] b);
        logic [1:0] c;
        c = 2'b00;
        case (b)
            4'b0010: c = 2'b01;
            4'b0100: c = 2'b10;
            4'b1000: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'd0;
            s     <= 4'd0;
        end else begin
            sync1 <= btn_in;
            s     <= sync1;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        snapshot_nxt = snapshot;
        colour_nxt   = colour_val;
        valid_nxt    = 1'b0;
        multi_nxt    = 1'b0;
        // Parking in RELEASE_DB while disabled forces a release before any new press counts.
        if (!en) begin
            state_nxt = RELEASE_DB;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (s != 4'd0) begin
                    snapshot_nxt = s;
                    cnt_nxt      = '0;
                    state_nxt    = PRESS_DB;
                end
                PRESS_DB: if (s != snapshot) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    if (snap_onehot) begin
                        colour_nxt = encode(snapshot);
                        valid_nxt  = 1'b1;
                    end else begin
                        multi_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                HELD: if (s == 4'd0) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE_DB;
                end
                RELEASE_DB: if (s != 4'd0) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                default: state_nxt = RELEASE_DB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RELEASE_DB;
            cnt          <= '0;
            snapshot     <= 4'd0;
            colour_val   <= 2'b00;
            colour_valid <= 1'b0;
            multi_press  <= 1'b0;
            btn_held     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            snapshot     <= snapshot_nxt;
            colour_val   <= colour_nxt;
            colour_valid <= valid_nxt;
            multi_press  <= multi_nxt;
            btn_held     <= (state_nxt == HELD) || (state_nxt == RELEASE_DB);
        end
    end

`ifdef BUTTON_CAPTURE_PRESS_COUNT_EN
    logic [7:0] press_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            press_cnt_q <= 8'd0;
        else if (valid_nxt && press_cnt_q != 8'hFF)
            press_cnt_q <= press_cnt_q + 8'd1;
    end
    assign press_count = press_cnt_q;
`else
    assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_button_capture.sv
// Bench for button_capture: table of press segments with a strobe scoreboard,
// plus hand sequences for reset-held, latency, release timing and reset mid-press.
`timescale 1ns/1ps
module tb_button_capture;
    localparam int DB = 4;
    localparam int K_NONE = 0, K_VALID = 1, K_MULTI = 2;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [3:0] btn_in = 4'd0;
    logic [1:0] colour_val;
    logic       colour_valid, multi_press, btn_held;
    logic [7:0] press_count;

    button_capture #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_in(btn_in),
        .colour_val(colour_val), .colour_valid(colour_valid),
        .multi_press(multi_press), .btn_held(btn_held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] btn;
        int         cycles;
        int         kind;
        logic [1:0] colour;
        int         held;   // 2 = don't check
    } vec_t;

    typedef struct {
        logic       multi;
        logic [1:0] colour;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    vec_t       tbl[$];
    int         total = 0, bad = 0;
    logic [1:0] exp_colour = 2'b00;
    int         exp_pc = 0;
    logic       prev_strobe = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pc_model();
`ifdef BUTTON_CAPTURE_PRESS_COUNT_EN
        return exp_pc;
`else
        return 0;
`endif
    endfunction

    function automatic vec_t mk(input logic e, input logic [3:0] b, input int cyc,
                                input int kind, input logic [1:0] c, input int held);
        vec_t v;
        v.en = e; v.btn = b; v.cycles = cyc; v.kind = kind; v.colour = c; v.held = held;
        return v;
    endfunction

    task automatic expect_strobe(input int kind, input logic [1:0] c);
        exp_t e;
        if (kind == K_VALID) begin
            exp_colour = c;
            e.multi = 1'b0; e.colour = c;
            exp_q.push_back(e);
            if (exp_pc < 255) exp_pc++;
        end else if (kind == K_MULTI) begin
            e.multi = 1'b1; e.colour = exp_colour;
            exp_q.push_back(e);
        end
    endtask

    task automatic apply(input vec_t v);
        en = v.en;
        btn_in = v.btn;
        expect_strobe(v.kind, v.colour);
        repeat (v.cycles) @(negedge clk);
        #1;
        check("pending_strobes", exp_q.size(), 0);
        if (v.held != 2) check("btn_held", btn_held, v.held);
        check("press_count", press_count, pc_model());
    endtask

    // Scoreboard: every strobe must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (colour_valid || multi_press) begin
                check("strobe_gap", prev_strobe, 0);
                check("strobe_excl", colour_valid & multi_press, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: valid=%0d multi=%0d at %0t",
                             colour_valid, multi_press, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind", multi_press, mon_e.multi);
                    check("colour_val", colour_val, mon_e.colour);
                end
            end
            prev_strobe = colour_valid | multi_press;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        // Button held through reset release must never be accepted.
        btn_in = 4'b0010;
        en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_colour_val", colour_val, 0);
        check("rst_colour_valid", colour_valid, 0);
        check("rst_multi_press", multi_press, 0);
        check("rst_btn_held", btn_held, 0);
        check("rst_press_count", press_count, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("held_thru_reset", btn_held, 1);
        check("held_thru_reset_colour", colour_val, 0);

        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        tbl.push_back(mk(1, 4'b0010, 10, K_VALID, 2'b01, 1));
        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        // bounce then stable
        tbl.push_back(mk(1, 4'b0001, 2,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b0000, 1,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b0001, 10, K_VALID, 2'b00, 1));
        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        tbl.push_back(mk(1, 4'b0100, 10, K_VALID, 2'b10, 1));
        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        // multi press keeps prior colour
        tbl.push_back(mk(1, 4'b1001, 10, K_MULTI, 2'b00, 1));
        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        // en dropped mid-debounce, raised while still pressed
        tbl.push_back(mk(1, 4'b1000, 4,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(0, 4'b1000, 3,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b1000, 8,  K_NONE,  2'b00, 1));
        tbl.push_back(mk(1, 4'b0000, 5,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b1000, 10, K_VALID, 2'b11, 1));
        tbl.push_back(mk(1, 4'b0000, 10, K_NONE,  2'b00, 0));
        // chatter and button changes during HELD
        tbl.push_back(mk(1, 4'b0100, 10, K_VALID, 2'b10, 1));
        tbl.push_back(mk(1, 4'b0000, 1,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b0100, 1,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b0000, 1,  K_NONE,  2'b00, 2));
        tbl.push_back(mk(1, 4'b0011, 3,  K_NONE,  2'b00, 1));
        tbl.push_back(mk(1, 4'b0000, 12, K_NONE,  2'b00, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Exact latency: strobe visible 7 negedges after driving (edge 0 is the next posedge).
        btn_in = 4'b0100;
        expect_strobe(K_VALID, 2'b10);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #1;
            check("latency_valid", colour_valid, (i == 7) ? 1 : 0);
        end
        check("latency_colour", colour_val, 2);
        btn_in = 4'b0000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #1;
            if (i == 5) check("release_still_held", btn_held, 1);
            if (i == 8) check("release_done", btn_held, 0);
        end

        // Counter saturation: 256 more presses.
        for (int n = 0; n < 256; n++) begin
            apply(mk(1, 4'b0010, 8,  K_VALID, 2'b01, 2));
            apply(mk(1, 4'b0000, 10, K_NONE,  2'b00, 2));
        end
        check("pc_saturated", press_count, pc_model());

        // Reset in the middle of a press: no strobe, outputs cleared.
        btn_in = 4'b0001;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        exp_pc = 0;
        exp_colour = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("midrst_valid", colour_valid, 0);
        check("midrst_count", press_count, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("midrst_held", btn_held, 1);
        apply(mk(1, 4'b0000, 12, K_NONE, 2'b00, 0));
        check("midrst_colour", colour_val, 0);

        repeat (5) @(negedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
